// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pc_sequencer_pkg                                        |
// | Purpose  : Shared types and defaults for the PC / bus sequencer.   |
// |            state_t values double as the state_dbg encodings.       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_TRAP   = 3'd4
  } state_t;

  localparam int C_DEFAULT_MEM_TIMEOUT = 16;
  localparam int C_DEFAULT_CNT_W       = 5;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_bus_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bus_wait_timer                                          |
// | Purpose  : Counts wait cycles of a bus access and flags expiry.    |
// |            Clears on request, saturates at TIMEOUT-1 (no wrap).    |
// | Ports    : clock, reset      - clock, sync active-high reset       |
// |            i_clear           - zero the counter this edge          |
// |            i_count_en        - count one more wait cycle           |
// |            o_expired         - counter has reached TIMEOUT-1       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module bus_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != C_LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pc_sequencer                                            |
// | Purpose  : Multi-cycle control FSM: instruction fetch, execute,    |
// |            data load/store, trap entry and bus-wait timeout.       |
// | Ports    : clock, reset           - clock, sync active-high reset  |
// |            mem_ready             - bus access completes this cycle|
// |            is_load/is_store/is_jump/is_branch/branch_taken         |
// |                                  - decode info, valid in EXEC     |
// |            trap_req              - level trap/interrupt request    |
// |            ir_load, mem_read, mem_write, pc_* , reg_write          |
// |                                  - combinational control strobes  |
// |            trap_ack, bus_error   - one-cycle event pulses          |
// |            state_dbg             - current state encoding          |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = C_DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = C_DEFAULT_CNT_W
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       is_jump,
  input  logic       is_branch,
  input  logic       branch_taken,
  input  logic       trap_req,
  output logic       ir_load,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic       pc_jump,
  output logic       pc_forward_address,
  output logic       pc_system_jump,
  output logic       pc_system_load,
  output logic       reg_write,
  output logic       trap_ack,
  output logic       bus_error,
  output logic [2:0] state_dbg
);

  state_t r_state;
  state_t w_next_state;
  state_t w_boundary;
  logic   r_trap_pending;
  logic   w_expired;
  logic   w_in_bus;

  logic w_ir_load, w_mem_read, w_mem_write, w_pc_write, w_pc_jump;
  logic w_pc_fwd, w_pc_sys_jump, w_pc_sys_load, w_reg_write;
  logic w_trap_ack, w_bus_error;

  // A request seen in the boundary cycle itself is honoured as well.
  assign w_boundary = (r_trap_pending || trap_req) ? ST_TRAP : ST_FETCH;
  assign w_in_bus   = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                      (r_state == ST_MEM_WR);

  always_comb begin
    w_next_state  = r_state;
    w_ir_load     = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_jump     = 1'b0;
    w_pc_fwd      = 1'b0;
    w_pc_sys_jump = 1'b0;
    w_pc_sys_load = 1'b0;
    w_reg_write   = 1'b0;
    w_trap_ack    = 1'b0;
    w_bus_error   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_read = 1'b1;
        if (mem_ready) begin
          w_ir_load    = 1'b1;
          w_next_state = ST_EXEC;
        end else if (w_expired) begin
          w_bus_error  = 1'b1;
          w_next_state = ST_TRAP;
        end
      end
      ST_EXEC: begin
        w_pc_write = 1'b1;
        w_pc_jump  = is_jump | (is_branch & branch_taken);
        if (is_load) begin
          w_next_state = ST_MEM_RD;
        end else if (is_store) begin
          w_next_state = ST_MEM_WR;
        end else begin
          // Non-memory instructions (including jumps writing the link) retire here.
          w_reg_write  = 1'b1;
          w_next_state = w_boundary;
        end
      end
      ST_MEM_RD: begin
        w_mem_read = 1'b1;
        w_pc_fwd   = 1'b1;
        if (mem_ready) begin
          w_reg_write  = 1'b1;
          w_next_state = w_boundary;
        end else if (w_expired) begin
          w_bus_error  = 1'b1;
          w_next_state = ST_TRAP;
        end
      end
      ST_MEM_WR: begin
        w_mem_write = 1'b1;
        w_pc_fwd    = 1'b1;
        if (mem_ready) begin
          w_next_state = w_boundary;
        end else if (w_expired) begin
          w_bus_error  = 1'b1;
          w_next_state = ST_TRAP;
        end
      end
      ST_TRAP: begin
        w_pc_write    = 1'b1;
        w_pc_sys_jump = 1'b1;
        w_pc_sys_load = 1'b1;
        w_trap_ack    = 1'b1;
        w_next_state  = ST_FETCH;
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_FETCH;
      r_trap_pending <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      // A fresh request in the trap cycle is kept for the next boundary.
      r_trap_pending <= trap_req | (r_trap_pending & (r_state != ST_TRAP));
    end
  end

  bus_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_next_state != r_state),
    .i_count_en (w_in_bus & ~mem_ready),
    .o_expired  (w_expired)
  );

  // Everything is forced quiet while reset is held, even mid-access.
  assign ir_load            = w_ir_load     & ~reset;
  assign mem_read           = w_mem_read    & ~reset;
  assign mem_write          = w_mem_write   & ~reset;
  assign pc_write           = w_pc_write    & ~reset;
  assign pc_jump            = w_pc_jump     & ~reset;
  assign pc_forward_address = w_pc_fwd      & ~reset;
  assign pc_system_jump     = w_pc_sys_jump & ~reset;
  assign pc_system_load     = w_pc_sys_load & ~reset;
  assign reg_write          = w_reg_write   & ~reset;
  assign trap_ack           = w_trap_ack    & ~reset;
  assign bus_error          = w_bus_error   & ~reset;
  assign state_dbg          = reset ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_pc_sequencer                                         |
// | Purpose  : Directed-vector scoreboard bench for pc_sequencer       |
// |            (MEM_TIMEOUT = 4).                                      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_pc_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mem_ready = 1'b0, is_load = 1'b0, is_store = 1'b0, is_jump = 1'b0;
  logic is_branch = 1'b0, branch_taken = 1'b0, trap_req = 1'b0;
  logic ir_load, mem_read, mem_write, pc_write, pc_jump, pc_forward_address;
  logic pc_system_jump, pc_system_load, reg_write, trap_ack, bus_error;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  pc_sequencer #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .mem_ready(mem_ready),
    .is_load(is_load), .is_store(is_store), .is_jump(is_jump),
    .is_branch(is_branch), .branch_taken(branch_taken), .trap_req(trap_req),
    .ir_load(ir_load), .mem_read(mem_read), .mem_write(mem_write),
    .pc_write(pc_write), .pc_jump(pc_jump),
    .pc_forward_address(pc_forward_address),
    .pc_system_jump(pc_system_jump), .pc_system_load(pc_system_load),
    .reg_write(reg_write), .trap_ack(trap_ack), .bus_error(bus_error),
    .state_dbg(state_dbg)
  );

  // Observation word: {state[2:0], ir, rd, wr, pcw, jmp, fwd, sysj, sysl, regw, tack, berr}
  localparam logic [13:0] S_F  = 14'h0000;
  localparam logic [13:0] S_E  = 14'h0800;
  localparam logic [13:0] S_R  = 14'h1000;
  localparam logic [13:0] S_W  = 14'h1800;
  localparam logic [13:0] S_T  = 14'h2000;
  localparam logic [13:0] IR   = 14'h0400;
  localparam logic [13:0] RD   = 14'h0200;
  localparam logic [13:0] WR   = 14'h0100;
  localparam logic [13:0] PCW  = 14'h0080;
  localparam logic [13:0] JMP  = 14'h0040;
  localparam logic [13:0] FWD  = 14'h0020;
  localparam logic [13:0] SYSJ = 14'h0010;
  localparam logic [13:0] SYSL = 14'h0008;
  localparam logic [13:0] REGW = 14'h0004;
  localparam logic [13:0] TACK = 14'h0002;
  localparam logic [13:0] BERR = 14'h0001;

  // Input vector: {reset, mem_ready, is_load, is_store, is_jump, is_branch, branch_taken, trap_req}
  localparam logic [7:0] I_RST = 8'h80;
  localparam logic [7:0] I_RDY = 8'h40;
  localparam logic [7:0] I_LD  = 8'h20;
  localparam logic [7:0] I_ST  = 8'h10;
  localparam logic [7:0] I_JMP = 8'h08;
  localparam logic [7:0] I_BR  = 8'h04;
  localparam logic [7:0] I_TK  = 8'h02;
  localparam logic [7:0] I_TRQ = 8'h01;

  logic [13:0] exp_q[$];
  int          id_q[$];
  int          total = 0;
  int          bad = 0;
  int          vec_n = 0;

  function automatic logic [13:0] observe();
    return {state_dbg, ir_load, mem_read, mem_write, pc_write, pc_jump,
            pc_forward_address, pc_system_jump, pc_system_load, reg_write,
            trap_ack, bus_error};
  endfunction

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      logic [13:0] a;
      int          id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = observe();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL vec%0d: outputs got=%014b want=%014b", id, a, e);
      end
    end
  end

  task automatic step(input logic [7:0] in, input logic [13:0] exp);
    @(posedge clock);
    #1;
    {reset, mem_ready, is_load, is_store, is_jump, is_branch, branch_taken, trap_req} = in;
    exp_q.push_back(exp);
    id_q.push_back(vec_n);
    vec_n++;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    step(I_RST,         S_F);                       // 0  reset cycle: all quiet
    step(I_RDY,         S_F | IR | RD);             // 1  fetch
    step(I_RDY,         S_E | PCW | REGW);          // 2  ALU exec
    step(I_RDY,         S_F | IR | RD);             // 3
    step(I_BR | I_TK,   S_E | PCW | JMP | REGW);    // 4  taken branch
    step(I_RDY,         S_F | IR | RD);             // 5
    step(I_BR,          S_E | PCW | REGW);          // 6  not-taken branch
    step(I_RDY,         S_F | IR | RD);             // 7
    step(I_LD,          S_E | PCW);                 // 8  load exec
    step(8'h00,         S_R | RD | FWD);            // 9  wait 1
    step(8'h00,         S_R | RD | FWD);            // 10 wait 2
    step(8'h00,         S_R | RD | FWD);            // 11 wait 3
    step(I_RDY,         S_R | RD | FWD | REGW);     // 12 ready on last count: no error
    step(I_RDY,         S_F | IR | RD);             // 13
    step(I_ST,          S_E | PCW);                 // 14 store exec
    step(I_TRQ,         S_W | WR | FWD);            // 15 trap pulse mid-store
    step(I_RDY,         S_W | WR | FWD);            // 16 store completes
    step(8'h00,         S_T | PCW | SYSJ | SYSL | TACK); // 17 trap entry
    step(8'h00,         S_F | RD);                  // 18 fetch stall 1
    step(8'h00,         S_F | RD);                  // 19 stall 2
    step(8'h00,         S_F | RD);                  // 20 stall 3
    step(8'h00,         S_F | RD | BERR);           // 21 4th cycle: timeout
    step(8'h00,         S_T | PCW | SYSJ | SYSL | TACK); // 22 trap after error
    step(8'h00,         S_F | RD);                  // 23
    step(8'h00,         S_F | RD);                  // 24
    step(8'h00,         S_F | RD);                  // 25
    step(I_RDY,         S_F | IR | RD);             // 26 ready on 4th cycle wins
    step(I_LD | I_ST,   S_E | PCW);                 // 27 load beats store
    step(8'h00,         S_R | RD | FWD);            // 28
    step(I_RST,         S_F);                       // 29 reset mid-read
    step(8'h00,         S_F | RD);                  // 30 back in fetch, no trap
    step(I_RDY,         S_F | IR | RD);             // 31
    step(I_JMP,         S_E | PCW | JMP | REGW);    // 32 jump writes link
    step(I_RDY,         S_F | IR | RD);             // 33 no pending trap
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clock);
        budget--;
      end
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: pending=%0d want=0", exp_q.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
